// File: rtl/mem_copy_master.sv
// mem_copy_master: DMA engine copying words over the PicoRV32 native memory bus
module mem_copy_master #(
  parameter int TIMEOUT = 256,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             mem_valid,
  output logic             mem_instr,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [31:0]      mem_rdata
);
  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;
  state_t state, state_n;
  logic [31:0] cur_src, cur_src_n, cur_dst, cur_dst_n, data_reg, data_n, wdog, wdog_n;
  logic [31:0] addr_n, wdata_n;
  logic [LEN_W-1:0] cnt, cnt_n;
  logic [3:0] wstrb_n;
  logic busy_n, done_n, err_n, valid_n, hs, stall, expire, bad;
  assign mem_instr = 1'b0;
  assign hs = mem_valid && mem_ready;
  assign stall = mem_valid && !mem_ready;
  assign expire = (TIMEOUT != 0) && stall && (wdog == 32'(TIMEOUT - 1));
  assign bad = |{src_addr[1:0], dst_addr[1:0]};
  // Outputs are computed here as next-values and registered below; a request is
  // raised only from a gap cycle, which yields the one-cycle low after each handshake.
  always_comb begin
    state_n = state;
    cur_src_n = cur_src;
    cur_dst_n = cur_dst;
    data_n = data_reg;
    cnt_n = cnt;
    busy_n = busy;
    done_n = 1'b0;
    err_n = err;
    valid_n = mem_valid;
    addr_n = mem_addr;
    wdata_n = mem_wdata;
    wstrb_n = mem_wstrb;
    wdog_n = stall ? wdog + 32'd1 : 32'd0;
    case (state)
      IDLE: if (start) begin
        cur_src_n = src_addr;
        cur_dst_n = dst_addr;
        cnt_n = len_words;
        err_n = bad;
        busy_n = 1'b1;
        if (bad || len_words == '0) state_n = FIN;
        else begin
          state_n = RD;
          valid_n = 1'b1;
          addr_n = src_addr;
          wstrb_n = 4'h0;
        end
      end
      RD: if (hs) begin
        data_n = mem_rdata;
        valid_n = 1'b0;
        state_n = WR;
      end else if (!mem_valid) begin
        valid_n = 1'b1;
        addr_n = cur_src;
        wstrb_n = 4'h0;
      end
      WR: if (hs) begin
        valid_n = 1'b0;
        cur_src_n = cur_src + 32'd4;
        cur_dst_n = cur_dst + 32'd4;
        cnt_n = cnt - 1'b1;
        state_n = (cnt == LEN_W'(1)) ? FIN : RD;
      end else if (!mem_valid) begin
        valid_n = 1'b1;
        addr_n = cur_dst;
        wdata_n = data_reg;
        wstrb_n = 4'hF;
      end
      FIN: begin
        busy_n = 1'b0;
        done_n = 1'b1;
        state_n = IDLE;
      end
    endcase
    if (expire) begin
      err_n = 1'b1;
      valid_n = 1'b0;
      state_n = FIN;
    end
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      cur_src <= '0;
      cur_dst <= '0;
      data_reg <= '0;
      cnt <= '0;
      wdog <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      mem_valid <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      state <= state_n;
      cur_src <= cur_src_n;
      cur_dst <= cur_dst_n;
      data_reg <= data_n;
      cnt <= cnt_n;
      wdog <= wdog_n;
      busy <= busy_n;
      done <= done_n;
      err <= err_n;
      mem_valid <= valid_n;
      mem_addr <= addr_n;
      mem_wdata <= wdata_n;
      mem_wstrb <= wstrb_n;
    end
endmodule

// File: tb/tb_mem_copy_master.sv
// tb_mem_copy_master: scoreboard bench with a wait-state memory responder and a copy model
module tb_mem_copy_master;
  typedef struct {logic [31:0] addr; logic [3:0] strb; logic [31:0] data;} tx_t;
  typedef struct {bit e; int lat; int ic;} job_t;
  logic clk, resetn, start, busy, done, err, mem_valid, mem_instr, mem_ready;
  logic [31:0] src_addr, dst_addr, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] len_words;
  logic [3:0] mem_wstrb;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [7:0] out_byte;
  tx_t exp_tx[$];
  job_t exp_job[$];
  int checks, passes, cyc, ws, wcnt;
  bit stuck;

  mem_copy_master #(.TIMEOUT(8), .LEN_W(16)) dut (
    .clk(clk), .resetn(resetn), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len_words(len_words), .busy(busy), .done(done), .err(err), .mem_valid(mem_valid),
    .mem_instr(mem_instr), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endfunction

  function automatic logic [31:0] rdm(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] rdm_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  // Memory responder: ws wait cycles per access, writes to 0x1000_0000 land on out_byte
  initial begin
    mem_ready = 0;
    mem_rdata = 0;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (!mem_valid || stuck) begin
        wcnt = 0;
        mem_ready = 0;
      end else if (wcnt < ws) begin
        wcnt++;
        mem_ready = 0;
      end else begin
        wcnt = 0;
        mem_ready = 1;
        if (mem_wstrb == 4'hF) begin
          mem[mem_addr] = mem_wdata;
          if (mem_addr == 32'h1000_0000) out_byte = mem_wdata[7:0];
        end else mem_rdata = rdm(mem_addr);
      end
    end
  end

  // Monitor: handshakes against expected transactions, done pulses against expected jobs
  initial begin
    tx_t t;
    job_t j;
    bit held, gap;
    logic [31:0] ha, hd;
    logic [3:0] hst;
    int l;
    held = 0;
    gap = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!resetn) begin
        held = 0;
        gap = 0;
      end else begin
        if (gap) chk(!mem_valid, "gap_after_ready", 32'(mem_valid), 0);
        gap = 0;
        if (mem_valid && held)
          chk(mem_addr == ha && mem_wstrb == hst && mem_wdata == hd, "hold_stable", mem_addr, ha);
        if (mem_valid && !held) begin
          ha = mem_addr;
          hst = mem_wstrb;
          hd = mem_wdata;
        end
        held = mem_valid;
        if (mem_valid && mem_ready) begin
          held = 0;
          gap = 1;
          if (exp_tx.size() == 0) chk(0, "extra_tx", mem_addr, 0);
          else begin
            t = exp_tx.pop_front();
            chk(mem_addr == t.addr, "tx_addr", mem_addr, t.addr);
            chk(mem_wstrb == t.strb, "tx_wstrb", 32'(mem_wstrb), 32'(t.strb));
            if (t.strb == 4'hF) chk(mem_wdata == t.data, "tx_wdata", mem_wdata, t.data);
          end
        end
        if (done) begin
          if (exp_job.size() == 0) chk(0, "extra_done", 1, 0);
          else begin
            j = exp_job.pop_front();
            l = cyc - (j.ic + 1);
            chk(err == j.e, "done_err", 32'(err), 32'(j.e));
            chk(!busy, "busy_at_done", 32'(busy), 0);
            if (j.lat == 0) chk(l >= 1 && l <= 2, "lat_trivial", l, 2);
            else chk(l == j.lat, "lat", l, j.lat);
          end
        end
      end
    end
  end

  task automatic issue(input logic [31:0] s, input logic [31:0] d, input int n, input int w, input bit tmo);
    bit bad;
    job_t j;
    logic [31:0] v;
    bad = (s[1:0] != 2'b0) || (d[1:0] != 2'b0);
    ws = w;
    if (!bad && !tmo)
      for (int i = 0; i < n; i++) begin
        v = rdm_ref(s + 32'(4 * i));
        exp_tx.push_back('{s + 32'(4 * i), 4'h0, 32'h0});
        exp_tx.push_back('{d + 32'(4 * i), 4'hF, v});
        ref_mem[d + 32'(4 * i)] = v;
      end
    @(negedge clk);
    start = 1;
    src_addr = s;
    dst_addr = d;
    len_words = n[15:0];
    j.ic = cyc;
    j.e = bad || tmo;
    j.lat = tmo ? 9 : (bad || n == 0) ? 0 : 2 * n * (w + 2);
    exp_job.push_back(j);
    @(negedge clk);
    start = 0;
    chk(busy, "busy_set", 32'(busy), 1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (exp_job.size() != 0 && k < 1000) begin
      @(negedge clk);
      #2;
      k++;
    end
    if (exp_job.size() != 0) begin
      chk(0, "done_timeout", exp_job.size(), 0);
      exp_job.delete();
      exp_tx.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [31:0] s, d, v0;
    int n, k, vc;
    #200000;
    $display("FAIL sim_timeout: got %0d, want finish", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] s, d, v0;
    int n, k, vc;
    checks = 0;
    passes = 0;
    cyc = 0;
    ws = 0;
    stuck = 0;
    out_byte = 0;
    resetn = 0;
    start = 0;
    src_addr = 0;
    dst_addr = 0;
    len_words = 0;
    for (int a = 0; a < 32'h800; a += 4) begin
      v0 = $urandom;
      mem[32'(a)] = v0;
      ref_mem[32'(a)] = v0;
    end
    mem[32'h100] = 32'h11; mem[32'h104] = 32'h22; mem[32'h108] = 32'h33; mem[32'h80] = 32'h41;
    ref_mem[32'h100] = 32'h11; ref_mem[32'h104] = 32'h22; ref_mem[32'h108] = 32'h33; ref_mem[32'h80] = 32'h41;
    repeat (3) @(negedge clk);
    chk({mem_valid, mem_instr, busy, done, err, mem_wstrb} == 9'h0, "reset_ctrl", 32'({mem_valid, busy, done, err, mem_wstrb}), 0);
    chk((mem_addr | mem_wdata) == 32'h0, "reset_bus", mem_addr | mem_wdata, 0);
    resetn = 1;
    @(negedge clk);
    // basic copy with always-ready memory
    issue(32'h100, 32'h200, 3, 0, 0);
    wait_idle();
    chk(mem[32'h208] == 32'h33, "copy_last_word", mem[32'h208], 32'h33);
    // wait states
    issue(32'h120, 32'h240, 2, 2, 0);
    wait_idle();
    // misaligned and empty jobs
    issue(32'h102, 32'h300, 2, 0, 0);
    wait_idle();
    chk(err, "err_sticky_misaligned", 32'(err), 1);
    issue(32'h100, 32'h300, 0, 0, 0);
    wait_idle();
    // watchdog with responder stuck
    stuck = 1;
    issue(32'h10, 32'h400, 2, 0, 1);
    vc = 0;
    while (mem_valid && vc < 50) begin
      vc++;
      @(negedge clk);
    end
    chk(vc == 8, "valid_cycles_before_abort", vc, 8);
    wait_idle();
    stuck = 0;
    chk(err && !busy, "err_after_timeout", 32'({err, busy}), 32'h2);
    // reset during the second write of a 4-word job
    s = 32'h40;
    d = 32'h300;
    ws = 2;
    v0 = rdm_ref(s);
    exp_tx.push_back('{s, 4'h0, 32'h0});
    exp_tx.push_back('{d, 4'hF, v0});
    exp_tx.push_back('{s + 32'd4, 4'h0, 32'h0});
    ref_mem[d] = v0;
    @(negedge clk);
    start = 1; src_addr = s; dst_addr = d; len_words = 16'd4;
    @(negedge clk);
    start = 0;
    k = 0;
    while (!(mem_valid && mem_wstrb == 4'hF && mem_addr == d + 32'd4) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(k < 200, "reach_second_write", k, 200);
    #2 resetn = 0;
    #1;
    chk({mem_valid, busy, done, err, mem_wstrb} == 8'h0, "midjob_reset_ctrl", 32'({mem_valid, busy, done, err, mem_wstrb}), 0);
    chk((mem_addr | mem_wdata) == 32'h0, "midjob_reset_bus", mem_addr | mem_wdata, 0);
    repeat (2) @(negedge clk);
    resetn = 1;
    chk(exp_tx.size() == 0, "partial_tx_count", exp_tx.size(), 0);
    @(negedge clk);
    // out_byte port, with a start ignored while busy
    issue(32'h80, 32'h1000_0000, 1, 0, 0);
    start = 1; src_addr = 32'h0; dst_addr = 32'h500; len_words = 16'd5;
    @(negedge clk);
    start = 0;
    wait_idle();
    repeat (20) @(negedge clk);
    chk(out_byte == 8'h41, "out_byte", 32'(out_byte), 32'h41);
    // address wrap
    issue(32'hFFFF_FFF8, 32'h600, 3, 1, 0);
    wait_idle();
    // randomized jobs
    for (int r = 0; r < 24; r++) begin
      s = 32'($urandom_range(0, 255)) * 4;
      d = 32'($urandom_range(0, 255)) * 4;
      n = $urandom_range(0, 6);
      if ($urandom_range(0, 7) == 0) s = s | 32'($urandom_range(1, 3));
      issue(s, d, n, $urandom_range(0, 3), 0);
      wait_idle();
    end
    chk(exp_tx.size() == 0, "tx_queue_empty", exp_tx.size(), 0);
    foreach (ref_mem[a]) chk(rdm(a) == ref_mem[a], "mem_final", rdm(a), ref_mem[a]);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
